// File: rtl/code_display_decoder.sv
// rtl/code_display_decoder.sv - keypad digit buffer with multiplexed 7-segment scan output
//
// Buffers up to NUM_DIGITS keypad entries in entry order and scans them onto a
// multiplexed common-cathode 7-segment display, one digit every SCAN_DIV clocks.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-low reset, clears all state
//   code_in   entry code {valid, bcd[3:0]}
//   load      single-cycle strobe: store code_in into the next free slot
//   clear     synchronous buffer clear; wins over a same-cycle load
//   seg_out   segments {g,f,e,d,c,b,a}, active-high, registered
//   dig_en    one-hot digit enable, active-high, registered
//   count     number of stored digits
//   full      count == NUM_DIGITS
//   load_ack  one-cycle pulse after an accepted load

module code_display_decoder #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [4:0]                        code_in,
  input  logic                              load,
  input  logic                              clear,
  output logic [6:0]                        seg_out,
  output logic [NUM_DIGITS-1:0]             dig_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full,
  output logic                              load_ack
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Digit buffer: slot data plus per-slot occupied flag; write pointer is count.
  logic [3:0]            slot [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] occ;

  // Scanner state.
  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;

  logic                  accept;
  logic [3:0]            cur_bcd;
  logic                  cur_occ;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] dig_nxt;

  assign full   = (count == CW'(NUM_DIGITS));
  // clear has priority, so a load in the same cycle is dropped without an ack.
  assign accept = load & code_in[4] & ~full & ~clear;

  // Buffer, count and acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      occ      <= '0;
      load_ack <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot[i] <= 4'h0;
      end
    end else begin
      load_ack <= accept;
      if (clear) begin
        occ   <= '0;
        count <= '0;
      end else if (accept) begin
        count <= count + CW'(1);
        // Loop-compare instead of slot[count] keeps the index width independent
        // of the count width; no wrap, since full blocks further loads.
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (count == CW'(i)) begin
            slot[i] <= code_in[3:0];
            occ[i]  <= 1'b1;
          end
        end
      end
    end
  end

  // Free-running scan divider and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      div <= div + DW'(1);
    end
  end

  // Select the scanned slot and build the matching one-hot enable.
  always_comb begin
    cur_bcd = 4'h0;
    cur_occ = 1'b0;
    dig_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_bcd    = slot[i];
        cur_occ    = occ[i];
        dig_nxt[i] = 1'b1;
      end
    end
  end

  // BCD to segments; non-decimal codes show a dash, empty slots are blank.
  always_comb begin
    seg_nxt = 7'h00;
    if (cur_occ) begin
      case (cur_bcd)
        4'd0:    seg_nxt = 7'h3F;
        4'd1:    seg_nxt = 7'h06;
        4'd2:    seg_nxt = 7'h5B;
        4'd3:    seg_nxt = 7'h4F;
        4'd4:    seg_nxt = 7'h66;
        4'd5:    seg_nxt = 7'h6D;
        4'd6:    seg_nxt = 7'h7D;
        4'd7:    seg_nxt = 7'h07;
        4'd8:    seg_nxt = 7'h7F;
        4'd9:    seg_nxt = 7'h6F;
        default: seg_nxt = 7'h40;
      endcase
    end
  end

  // Segments and enable register together so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out <= 7'h00;
      dig_en  <= '0;
    end else begin
      seg_out <= seg_nxt;
      dig_en  <= dig_nxt;
    end
  end

endmodule

// File: doc/code_display_decoder.md
# code_display_decoder

Display-side counterpart of the keypad input encoder. Accepts 5-bit entry codes ({valid, BCD}) from the keypad path, buffers up to NUM_DIGITS entered digits in entry order, and scans them onto a multiplexed common-cathode 7-segment display. Sits between the keypad entry logic and the board display pins.

## Interface
- NUM_DIGITS, 3: buffer depth and number of display digits (2..8)
- SCAN_DIV, 4: clock cycles each digit stays enabled (>=2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-low; clears all state
- code_in  input  5  entry code: bit4 = valid, bits3:0 = BCD digit
- load  input  1  single-cycle strobe; store code_in into next free slot
- clear  input  1  synchronous; empties buffer
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
- dig_en  output  NUM_DIGITS  one-hot digit enable, active-high, registered
- count  output  clog2(NUM_DIGITS+1)  number of stored digits
- full  output  1  count == NUM_DIGITS
- load_ack  output  1  one-cycle pulse: previous-cycle load was accepted

## Operation
- Buffer: NUM_DIGITS slots of 4 bits plus per-slot occupied flag; write pointer wptr = count.
- Load accepted iff load=1, code_in[4]=1, full=0, clear=0: slot[wptr] <= code_in[3:0], occupied set, count+1, load_ack=1 next cycle.
- Rejected loads (valid bit 0, or full) leave all state unchanged, no load_ack. No wrap-around: slot 0 is never overwritten until clear.
- clear: all occupied flags 0, count 0. clear and load in same cycle: clear wins, load dropped, no load_ack.
- Scanner: divider div counts 0..SCAN_DIV-1; at div == SCAN_DIV-1, div -> 0 and scan index idx -> (idx+1) mod NUM_DIGITS. Runs continuously regardless of load/clear.
- Decode of slot[idx]: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F (hex); BCD 10..15 (only reachable via malformed code_in) -> 40 (dash); unoccupied slot -> 00 (blank).
- dig_en = one-hot of idx (bit idx set); seg_out = decode of slot[idx].

## Timing
- Reset (rst=0, any time, independent of clk): seg_out=0, dig_en=0, count=0, full=0, load_ack=0, div=0, idx=0, all slots unoccupied. Mid-scan or mid-load reset discards everything immediately.
- First rising edge after rst release: dig_en=001 (NUM_DIGITS=3), seg_out=00.
- seg_out/dig_en are registered from idx and buffer state: one-cycle latency. Load accepted at edge N into the slot currently scanned -> seg_out shows new digit after edge N+1.
- count/full update at the same edge that accepts the load; load_ack high for exactly the cycle after that edge.
- Each digit enable held exactly SCAN_DIV cycles; full frame = NUM_DIGITS*SCAN_DIV cycles; no blank cycles between digits.
- seg_out and dig_en always change on the same edge (no ghosting).
- load held high for multiple cycles is treated as one load per cycle (caller provides single-cycle strobes).

## Test plan
- Reset: drive rst=0 mid-scan with 2 digits stored -> all outputs 0 asynchronously; after release, first edge dig_en=001, seg_out=00, count=0.
- Load sequence 5'h13, 5'h17, 5'h19 (digits 3,7,9) -> count 1,2,3, full=1 after third, load_ack pulse per load; scan shows 4F on 001, 07 on 010, 6F on 100, each for 4 cycles, repeating every 12 cycles.
- Overflow: full, load 5'h12 -> no load_ack, count stays 3, scanned digits unchanged (3,7,9).
- Invalid code: load with code_in=5'h05 (valid=0) -> rejected, count unchanged; load 5'h1C -> accepted, displays 40.
- Clear vs load same cycle with count=2 -> count=0, full=0, no load_ack, all digits blank (00) next frame; following load 5'h10 lands in slot 0 showing 3F.
- Latency: load 5'h18 on the edge where idx=0 -> seg_out=7F exactly one edge later while dig_en=001.
